// File: rtl/lut_weight_streamer.sv
// Reads one tensor from LUT storage over a byte-wide synchronous port and streams it as LANES-wide
// beats. Optional running word checksum output when LUT_STREAM_CHECKSUM_EN is defined.
module lut_weight_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lut_done,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_base,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*LANES-1:0] m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
`ifdef LUT_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]                 checksum
`endif
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BeatW = DATA_WIDTH * LANES;

  typedef enum logic [1:0] {StIdle, StWaitLut, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q, iss_idx_q, ret_idx_q;
  logic [LaneW-1:0]      ret_lane_q;
  logic                  rd_pend_q, open_q, done_q, done_d;
  logic [BeatW-1:0]      gather_q, beat_data;
  logic [BeatW-1:0]      fifo_data_q [2];
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, credit;
  logic                  accept, pop, push, last_ret;

  assign accept   = (state_q == StIdle) && start;
  assign m_valid  = (cnt_q != 2'd0);
  assign pop      = m_valid && m_ready;
  assign last_ret = rd_pend_q && (ret_idx_q == len_q - LEN_WIDTH'(1));
  assign push     = rd_pend_q && ((ret_lane_q == LaneW'(LANES - 1)) || last_ret);
  // Beats queued (net of this cycle's pop) plus a beat under construction.
  assign credit   = 2'(cnt_q - {1'b0, pop}) + {1'b0, open_q};
  assign rd_en    = (state_q == StFetch) && (credit < 2'd2);
  assign rd_addr  = base_q + ADDR_WIDTH'(iss_idx_q);
  assign m_data   = fifo_data_q[rd_ptr_q];
  assign m_last   = fifo_last_q[rd_ptr_q] && m_valid;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_comb begin
    beat_data = gather_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (ret_lane_q == LaneW'(k)) beat_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!lut_done)             state_d = StWaitLut;
          else if (cfg_len == '0)    done_d  = 1'b1;
          else                       state_d = StFetch;
        end
      end
      StWaitLut: begin
        if (lut_done) begin
          if (len_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (rd_en && (iss_idx_q == len_q - LEN_WIDTH'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (pop && m_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      done_q         <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      iss_idx_q      <= '0;
      ret_idx_q      <= '0;
      ret_lane_q     <= '0;
      rd_pend_q      <= 1'b0;
      open_q         <= 1'b0;
      gather_q       <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      rd_pend_q <= rd_en;
      open_q    <= (open_q && !push) || rd_en;
      if (accept) begin
        base_q     <= cfg_base;
        len_q      <= cfg_len;
        iss_idx_q  <= '0;
        ret_idx_q  <= '0;
        ret_lane_q <= '0;
        gather_q   <= '0;
      end else begin
        if (rd_en) iss_idx_q <= iss_idx_q + LEN_WIDTH'(1);
        if (rd_pend_q) begin
          ret_idx_q  <= ret_idx_q + LEN_WIDTH'(1);
          ret_lane_q <= (ret_lane_q == LaneW'(LANES - 1)) ? '0 : ret_lane_q + LaneW'(1);
          // Clearing after a push leaves unfilled lanes of a short final beat at zero.
          gather_q   <= push ? '0 : beat_data;
        end
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= beat_data;
        fifo_last_q[wr_ptr_q] <= last_ret;
        wr_ptr_q              <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef LUT_STREAM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (rd_pend_q) begin
      sum_q <= sum_q + 16'(rd_data);
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_lut_weight_streamer.sv
// Directed bench for lut_weight_streamer; LUT model returns the low address byte one cycle later.
module tb_lut_weight_streamer;
  logic        clk = 1'b0, rst = 1'b0, lut_done = 1'b0, start = 1'b0;
  logic [11:0] cfg_base = '0;
  logic [8:0]  cfg_len = '0;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        m_valid, m_ready = 1'b0, m_last, busy, done;
  logic [31:0] m_data;
`ifdef LUT_STREAM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;

  lut_weight_streamer dut (
    .clk(clk), .rst(rst), .lut_done(lut_done), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
`ifdef LUT_STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  // Monitor: logs reads, handshakes and done pulses with their cycle numbers.
  logic [31:0] beat_log [$];
  logic        last_log [$];
  int          hs_cyc [$];
  logic [11:0] rd_log [$];
  int          rd_cyc [$];
  int          done_cnt = 0, done_cyc = 0, stable_err = 0;
  logic        busy_at_done = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
  logic [31:0] data_prev = '0;

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        rd_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        beat_log.push_back(m_data);
        last_log.push_back(m_last);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt     <= done_cnt + 1;
        done_cyc     <= cyc;
        busy_at_done <= busy;
      end
      if (stall_prev && (!m_valid || m_data !== data_prev || m_last !== last_prev))
        stable_err <= stable_err + 1;
      stall_prev <= m_valid && !m_ready;
      data_prev  <= m_data;
      last_prev  <= m_last;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_xfer(input logic [11:0] b, input logic [8:0] l);
    cfg_base = b;
    cfg_len  = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    n_cmp++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s_timeout: done count %0d, required > %0d within %0d cycles",
               name, done_cnt, d0, budget);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (rd_en !== 1'b0)   begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (rd_addr !== '0)   begin n_fail++; $display("FAIL rst_rd_addr: got %h want 0", rd_addr); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0)    begin n_fail++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    n_cmp++; if ({m_last, busy, done} !== 3'b000)
      begin n_fail++; $display("FAIL rst_last_busy_done: got %b want 000", {m_last, busy, done}); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int b0 = beat_log.size(), r0 = rd_log.size(), d0 = done_cnt;
    logic [31:0] exp [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    lut_done = 1'b1;
    m_ready  = 1'b1;
    start_xfer(12'h010, 9'd16);
    wait_done(d0, 100, "basic");
    n_cmp++; if (beat_log.size() - b0 != 4)
      begin n_fail++; $display("FAIL basic_beats: got %0d want 4", beat_log.size() - b0); end
    n_cmp++; if (rd_log.size() - r0 != 16)
      begin n_fail++; $display("FAIL basic_reads: got %0d want 16", rd_log.size() - r0); end
    for (int i = 0; i < 4 && b0 + i < beat_log.size(); i++) begin
      n_cmp++; if (beat_log[b0+i] !== exp[i] || last_log[b0+i] !== (i == 3))
        begin n_fail++; $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, beat_log[b0+i],
                                 last_log[b0+i], exp[i], (i == 3)); end
    end
    if (beat_log.size() - b0 == 4 && rd_log.size() - r0 == 16) begin
      n_cmp++; if (done_cyc != hs_cyc[b0+3] + 1)
        begin n_fail++; $display("FAIL basic_done_timing: got cyc %0d want %0d", done_cyc, hs_cyc[b0+3] + 1); end
      n_cmp++; if (hs_cyc[b0] - rd_cyc[r0] != 5)
        begin n_fail++; $display("FAIL basic_latency: got %0d want 5", hs_cyc[b0] - rd_cyc[r0]); end
      n_cmp++; if (hs_cyc[b0+3] - hs_cyc[b0] != 12)
        begin n_fail++; $display("FAIL basic_throughput: got %0d want 12", hs_cyc[b0+3] - hs_cyc[b0]); end
    end
    n_cmp++; if (busy_at_done !== 1'b0)
      begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
`ifdef LUT_STREAM_CHECKSUM_EN
    tick(3);
    n_cmp++; if (checksum !== 16'd376)
      begin n_fail++; $display("FAIL basic_checksum: got %0d want 376", checksum); end
`endif
  endtask

  task automatic test_partial();
    int b0 = beat_log.size(), d0 = done_cnt;
    logic [31:0] exp [2] = '{32'h03020100, 32'h00000504};
    start_xfer(12'h000, 9'd6);
    wait_done(d0, 100, "partial");
    n_cmp++; if (beat_log.size() - b0 != 2)
      begin n_fail++; $display("FAIL partial_beats: got %0d want 2", beat_log.size() - b0); end
    for (int i = 0; i < 2 && b0 + i < beat_log.size(); i++) begin
      n_cmp++; if (beat_log[b0+i] !== exp[i] || last_log[b0+i] !== (i == 1))
        begin n_fail++; $display("FAIL partial_beat%0d: got %h/%b want %h/%b", i, beat_log[b0+i],
                                 last_log[b0+i], exp[i], (i == 1)); end
    end
`ifdef LUT_STREAM_CHECKSUM_EN
    n_cmp++; if (checksum !== 16'd15)
      begin n_fail++; $display("FAIL partial_checksum: got %0d want 15", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    int b0 = beat_log.size(), d0 = done_cnt, s0 = stable_err;
    logic [31:0] exp [2] = '{32'h03020100, 32'h07060504};
    start_xfer(12'h000, 9'd8);
    for (int k = 0; k < 200 && done_cnt == d0; k++) begin
      m_ready = (k % 4 == 0);
      tick();
    end
    m_ready = 1'b1;
    wait_done(d0, 10, "bp");
    n_cmp++; if (beat_log.size() - b0 != 2)
      begin n_fail++; $display("FAIL bp_beats: got %0d want 2", beat_log.size() - b0); end
    for (int i = 0; i < 2 && b0 + i < beat_log.size(); i++) begin
      n_cmp++; if (beat_log[b0+i] !== exp[i] || last_log[b0+i] !== (i == 1))
        begin n_fail++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, beat_log[b0+i],
                                 last_log[b0+i], exp[i], (i == 1)); end
    end
    n_cmp++; if (stable_err != s0)
      begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stable_err - s0); end
  endtask

  task automatic test_full_stall();
    int b0 = beat_log.size(), r0 = rd_log.size(), d0 = done_cnt, s0 = stable_err;
    logic [31:0] exp [4] = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
    m_ready = 1'b0;
    start_xfer(12'h040, 9'd16);
    tick(20);
    n_cmp++; if (rd_log.size() - r0 < 4 || rd_log.size() - r0 > 12)
      begin n_fail++; $display("FAIL stall_reads: got %0d want 4..12", rd_log.size() - r0); end
    n_cmp++; if (m_valid !== 1'b1 || m_data !== exp[0])
      begin n_fail++; $display("FAIL stall_head: got %b/%h want 1/%h", m_valid, m_data, exp[0]); end
    m_ready = 1'b1;
    wait_done(d0, 100, "stall");
    n_cmp++; if (beat_log.size() - b0 != 4)
      begin n_fail++; $display("FAIL stall_beats: got %0d want 4", beat_log.size() - b0); end
    for (int i = 0; i < 4 && b0 + i < beat_log.size(); i++) begin
      n_cmp++; if (beat_log[b0+i] !== exp[i])
        begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, beat_log[b0+i], exp[i]); end
    end
    n_cmp++; if (stable_err != s0)
      begin n_fail++; $display("FAIL stall_stable: got %0d unstable stalls want 0", stable_err - s0); end
  endtask

  task automatic test_wait_lut();
    int b0 = beat_log.size(), r0 = rd_log.size(), d0 = done_cnt;
    lut_done = 1'b0;
    start_xfer(12'h080, 9'd4);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wl_busy: got %b want 1", busy); end
    start_xfer(12'h200, 9'd8);
    tick(3);
    n_cmp++; if (rd_log.size() != r0)
      begin n_fail++; $display("FAIL wl_no_read: got %0d reads want 0", rd_log.size() - r0); end
    lut_done = 1'b1;
    tick(2);
    start_xfer(12'h300, 9'd8);
    wait_done(d0, 100, "wl");
    tick(10);
    n_cmp++; if (done_cnt - d0 != 1)
      begin n_fail++; $display("FAIL wl_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (rd_log.size() - r0 != 4)
      begin n_fail++; $display("FAIL wl_reads: got %0d want 4", rd_log.size() - r0); end
    n_cmp++; if (beat_log.size() - b0 != 1)
      begin n_fail++; $display("FAIL wl_beats: got %0d want 1", beat_log.size() - b0); end
    else if (beat_log[b0] !== 32'h83828180 || last_log[b0] !== 1'b1)
      begin n_fail++; $display("FAIL wl_beat: got %h/%b want 83828180/1", beat_log[b0], last_log[b0]); end
  endtask

  task automatic test_wrap();
    int b0 = beat_log.size(), r0 = rd_log.size(), d0 = done_cnt;
    logic [11:0] exp [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    start_xfer(12'hFFE, 9'd4);
    wait_done(d0, 100, "wrap");
    n_cmp++; if (rd_log.size() - r0 != 4)
      begin n_fail++; $display("FAIL wrap_reads: got %0d want 4", rd_log.size() - r0); end
    for (int i = 0; i < 4 && r0 + i < rd_log.size(); i++) begin
      n_cmp++; if (rd_log[r0+i] !== exp[i])
        begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, rd_log[r0+i], exp[i]); end
    end
    n_cmp++; if (beat_log.size() - b0 != 1 || beat_log[beat_log.size()-1] !== 32'h0100FFFE)
      begin n_fail++; $display("FAIL wrap_beat: got %0d beats last %h want 1 beat 0100fffe",
                               beat_log.size() - b0, beat_log[beat_log.size()-1]); end
  endtask

  task automatic test_zero_len();
    int b0 = beat_log.size(), r0 = rd_log.size(), d0 = done_cnt, st;
    st = cyc;
    start_xfer(12'h123, 9'd0);
    tick(4);
    n_cmp++; if (done_cnt - d0 != 1)
      begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_cyc != st + 1)
      begin n_fail++; $display("FAIL zero_done_timing: got cyc %0d want %0d", done_cyc, st + 1); end
    n_cmp++; if (beat_log.size() != b0 || rd_log.size() != r0)
      begin n_fail++; $display("FAIL zero_activity: got %0d beats %0d reads want 0/0",
                               beat_log.size() - b0, rd_log.size() - r0); end
  endtask

  task automatic test_abort();
    int b0, d0 = done_cnt;
    m_ready = 1'b0;
    start_xfer(12'h030, 9'd4);
    tick(10);
    n_cmp++; if (m_valid !== 1'b1 || busy !== 1'b1)
      begin n_fail++; $display("FAIL abort_pre: got valid %b busy %b want 1 1", m_valid, busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({rd_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== '0 || rd_addr !== '0)
      begin n_fail++; $display("FAIL abort_outputs: got %b data %h addr %h want zeros",
                               {rd_en, m_valid, m_last, busy, done}, m_data, rd_addr); end
    tick(3);
    rst = 1'b1;
    tick(2);
    n_cmp++; if (done_cnt != d0)
      begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    b0 = beat_log.size();
    m_ready = 1'b1;
    start_xfer(12'h050, 9'd4);
    wait_done(d0, 100, "abort_restart");
    n_cmp++; if (beat_log.size() - b0 != 1)
      begin n_fail++; $display("FAIL abort_restart_beats: got %0d want 1", beat_log.size() - b0); end
    else if (beat_log[b0] !== 32'h53525150 || last_log[b0] !== 1'b1)
      begin n_fail++; $display("FAIL abort_restart_beat: got %h/%b want 53525150/1",
                               beat_log[b0], last_log[b0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_full_stall();
    test_wait_lut();
    test_wrap();
    test_zero_len();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
